// File: rtl/dmem_mmio.sv
// dmem_mmio: data-side responder for the core, with word RAM plus an MMIO page holding a compare timer and an output FIFO.
module dmem_mmio #(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        irq
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);
  logic [31:0]   r_ram  [RAM_WORDS];
  logic [31:0]   r_fifo [FIFO_DEPTH];
  logic [31:0]   r_tcnt, r_tcmp;
  logic          r_en, r_match, r_ovf;
  logic [PW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic [31:0]   w_a, w_status;
  logic          w_ram, w_wtcnt, w_wtcmp, w_wstat, w_push, w_wctrl;
  logic          w_full, w_pop, w_acc, w_hit;
  always_comb begin
    w_a      = a & ~32'h3;
    w_ram    = w_a < RAM_BYTES;
    w_wtcnt  = we && w_a == 32'h100;
    w_wtcmp  = we && w_a == 32'h104;
    w_wstat  = we && w_a == 32'h108;
    w_push   = we && w_a == 32'h10C;
    w_wctrl  = we && w_a == 32'h110;
    w_full   = r_cnt == CW'(FIFO_DEPTH);
    out_valid = r_cnt != '0;
    out_data = out_valid ? r_fifo[r_rp] : 32'd0;
    w_pop    = out_valid && out_ready;
    w_acc    = w_push && (!w_full || w_pop);
    w_hit    = r_en && r_tcnt == r_tcmp;
    irq      = r_match;
    w_status = {23'd0, 5'(r_cnt), r_ovf, !out_valid, w_full, r_match};
    rd = w_ram               ? r_ram[w_a[AW+1:2]] :
         w_a == 32'h100      ? r_tcnt :
         w_a == 32'h104      ? r_tcmp :
         w_a == 32'h108      ? w_status :
         w_a == 32'h110      ? {31'd0, r_en} : 32'd0;
  end
  // Storage arrays carry no reset; FIFO validity lives in the pointers and count.
  always_ff @(posedge clk) begin
    if (we && w_ram) r_ram[w_a[AW+1:2]] <= wd;
    if (w_acc) r_fifo[r_wp] <= wd;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tcnt  <= '0;
      r_tcmp  <= '0;
      r_en    <= 1'b0;
      r_match <= 1'b0;
      r_ovf   <= 1'b0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
    end else begin
      r_tcnt  <= w_wtcnt ? wd : r_en ? r_tcnt + 32'd1 : r_tcnt;
      if (w_wtcmp) r_tcmp <= wd;
      if (w_wctrl) r_en <= wd[0];
      r_match <= w_hit || (r_match && !(w_wstat && wd[0]));
      r_ovf   <= (w_push && w_full && !w_pop) || (r_ovf && !(w_wstat && wd[3]));
      if (w_acc) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt   <= r_cnt + CW'(w_acc) - CW'(w_pop);
    end
  end
endmodule
